// File: rtl/axil_pkg.sv
// Shared AXI4-Lite read-path types: response codes and read-side FSM states.
package axil_pkg;

   typedef logic [1:0] resp_t;

   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } rd_state_t;

endpackage

// File: rtl/axil_regbank.sv
// Register bank: flop array with a local write port and a combinational read mux.
module axil_regbank #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REGS   = 16,
   parameter int unsigned IDX_W      = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [IDX_W-1:0]      rd_idx,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

   // Register storage; a write in the same cycle as a read sample lands after it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         regs_q[wr_idx] <= wr_data;
      end
   end

   // Read mux by index.
   always_comb begin
      rd_data = regs_q[rd_idx];
   end

endmodule

// File: rtl/axil_rd_slave_regbank.sv
// AXI4-Lite read-only slave answering AR/R from a local register bank with
// programmable latency and range/alignment checking.
module axil_rd_slave_regbank
   import axil_pkg::*;
#(
   parameter int unsigned            ADDR_WIDTH = 32,
   parameter int unsigned            DATA_WIDTH = 32,
   parameter int unsigned            NUM_REGS   = 16,
   parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0,
   parameter int unsigned            RD_LATENCY = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ADDR_WIDTH-1:0]       ARADDR,
   input  logic                        ARVALID,
   output logic                        ARREADY,
   output logic                        RVALID,
   output logic [DATA_WIDTH-1:0]       RDATA,
   output logic [1:0]                  RRESP,
   input  logic                        RREADY,
   input  logic                        loc_wr_en,
   input  logic [$clog2(NUM_REGS)-1:0] loc_wr_idx,
   input  logic [DATA_WIDTH-1:0]       loc_wr_data,
   output logic                        busy
);

   localparam int unsigned IDX_W = $clog2(NUM_REGS);
   localparam int unsigned CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
   localparam logic [ADDR_WIDTH-1:0] BANK_BYTES = ADDR_WIDTH'(NUM_REGS * 4);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

   rd_state_t             state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  err_q, err_d;
   logic                  arready_q, arready_d;
   logic                  rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   resp_t                 rresp_q, rresp_d;

   logic [ADDR_WIDTH-1:0] off;
   logic                  addr_err;
   logic [DATA_WIDTH-1:0] bank_rd_data;

   axil_regbank #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .IDX_W      (IDX_W)
   ) u_regbank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (loc_wr_en),
      .wr_idx  (loc_wr_idx),
      .wr_data (loc_wr_data),
      .rd_idx  (idx_q),
      .rd_data (bank_rd_data)
   );

   // Address decode on the live AR address; result is captured at the handshake.
   always_comb begin
      off      = ARADDR - BASE_ADDR;
      addr_err = (ARADDR < BASE_ADDR) || (off >= BANK_BYTES) || (ARADDR[1:0] != 2'b00);
   end

   // Next-state and registered-output logic for the AR -> WAIT -> R sequence.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      err_d     = err_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      unique case (state_q)
         IDLE: begin
            arready_d = 1'b1;
            if (ARVALID && arready_q) begin
               arready_d = 1'b0;
               idx_d     = off[IDX_W+1:2];
               err_d     = addr_err;
               cnt_d     = CNT_LOAD;
               state_d   = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               // Bank is sampled here, not at the handshake.
               rdata_d  = err_q ? '0 : bank_rd_data;
               rresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
               rvalid_d = 1'b1;
               state_d  = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            if (RREADY) begin
               rvalid_d  = 1'b0;
               rdata_d   = '0;
               rresp_d   = RESP_OKAY;
               arready_d = 1'b1;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any transaction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         err_q     <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         err_q     <= err_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   assign ARREADY = arready_q;
   assign RVALID  = rvalid_q;
   assign RDATA   = rdata_q;
   assign RRESP   = rresp_q;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_axil_rd_slave_regbank.sv
// Directed bench for axil_rd_slave_regbank: table of reads plus hand-written
// sequences for back-pressure, write collision and mid-transaction reset.
module tb_axil_rd_slave_regbank;

   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam int          LAT  = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ARADDR;
   logic        ARVALID;
   logic        ARREADY;
   logic        RVALID;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RREADY;
   logic        loc_wr_en;
   logic [3:0]  loc_wr_idx;
   logic [31:0] loc_wr_data;
   logic        busy;

   int total = 0;
   int bad   = 0;

   axil_rd_slave_regbank #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .NUM_REGS   (16),
      .BASE_ADDR  (BASE),
      .RD_LATENCY (LAT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ARADDR      (ARADDR),
      .ARVALID     (ARVALID),
      .ARREADY     (ARREADY),
      .RVALID      (RVALID),
      .RDATA       (RDATA),
      .RRESP       (RRESP),
      .RREADY      (RREADY),
      .loc_wr_en   (loc_wr_en),
      .loc_wr_idx  (loc_wr_idx),
      .loc_wr_data (loc_wr_data),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  resp;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Steps one cycle; all driving and sampling happens 1 time unit after posedge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic loc_write(input logic [3:0] idx, input logic [31:0] data);
      loc_wr_en   = 1'b1;
      loc_wr_idx  = idx;
      loc_wr_data = data;
      tick();
      loc_wr_en = 1'b0;
   endtask

   // Presents an address and returns just after the handshake edge.
   task automatic ar_issue(input logic [31:0] addr);
      int n;
      ARADDR  = addr;
      ARVALID = 1'b1;
      n = 0;
      while (!ARREADY && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk("arready_timeout", 64'(ARREADY), 64'd1);
      tick();
      ARVALID = 1'b0;
   endtask

   task automatic wait_rvalid(output int lat);
      lat = 0;
      while (!RVALID && lat < 50) begin
         tick();
         lat++;
      end
      if (lat >= 50) chk("rvalid_timeout", 64'(RVALID), 64'd1);
   endtask

   // Holds RREADY low for `hold` cycles checking stability, then completes.
   task automatic r_finish(input int hold, input string tag);
      logic [31:0] d0;
      logic [1:0]  r0;
      d0 = RDATA;
      r0 = RRESP;
      for (int k = 0; k < hold; k++) begin
         tick();
         chk({tag, "_hold_rvalid"}, 64'(RVALID), 64'd1);
         chk({tag, "_hold_rdata"}, 64'(RDATA), 64'(d0));
         chk({tag, "_hold_rresp"}, 64'(RRESP), 64'(r0));
         chk({tag, "_hold_arready"}, 64'(ARREADY), 64'd0);
      end
      RREADY = 1'b1;
      tick();
      RREADY = 1'b0;
      chk({tag, "_done_rvalid"}, 64'(RVALID), 64'd0);
      chk({tag, "_done_rdata"}, 64'(RDATA), 64'd0);
      chk({tag, "_done_arready"}, 64'(ARREADY), 64'd1);
      chk({tag, "_done_busy"}, 64'(busy), 64'd0);
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_d,
                          input logic [1:0] exp_r, input string tag);
      int lat;
      ar_issue(addr);
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      wait_rvalid(lat);
      chk({tag, "_latency"}, 64'(lat), 64'(LAT));
      chk({tag, "_rdata"}, 64'(RDATA), 64'(exp_d));
      chk({tag, "_rresp"}, 64'(RRESP), 64'(exp_r));
      r_finish(0, tag);
   endtask

   initial begin
      int lat;

      vecs[0] = '{BASE + 32'h0C,   32'hDEAD_BEEF, 2'b00};
      vecs[1] = '{BASE + 32'h00,   32'hA5A5_0000, 2'b00};
      vecs[2] = '{BASE + 32'h3C,   32'hA5A5_000F, 2'b00};
      vecs[3] = '{BASE + 32'h40,   32'h0,         2'b10};
      vecs[4] = '{BASE + 32'h06,   32'h0,         2'b10};
      vecs[5] = '{BASE - 32'h04,   32'h0,         2'b10};
      vecs[6] = '{BASE + 32'h1000, 32'h0,         2'b10};
      vecs[7] = '{BASE + 32'h20,   32'hA5A5_0008, 2'b00};

      rst         = 1'b1;
      ARADDR      = '0;
      ARVALID     = 1'b0;
      RREADY      = 1'b0;
      loc_wr_en   = 1'b0;
      loc_wr_idx  = '0;
      loc_wr_data = '0;

      // Reset values.
      #13;
      chk("rst_arready", 64'(ARREADY), 64'd0);
      chk("rst_rvalid", 64'(RVALID), 64'd0);
      chk("rst_rdata", 64'(RDATA), 64'd0);
      chk("rst_rresp", 64'(RRESP), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      #4;
      rst = 1'b0;
      chk("post_rst_arready_low", 64'(ARREADY), 64'd0);
      tick();
      chk("post_rst_arready_high", 64'(ARREADY), 64'd1);

      // Preload bank; reg[5] stays zero for the collision case.
      for (int i = 0; i < 16; i++) begin
         loc_write(4'(i), (i == 5) ? 32'h0 : 32'hA5A5_0000 + 32'(i));
      end
      loc_write(4'd3, 32'hDEAD_BEEF);

      // Table-driven reads.
      for (int i = 0; i < 8; i++) begin
         do_read(vecs[i].addr, vecs[i].data, vecs[i].resp, $sformatf("vec%0d", i));
      end

      // Back-pressure: RREADY low for 5 cycles.
      ar_issue(BASE + 32'h0C);
      wait_rvalid(lat);
      chk("bp_rdata", 64'(RDATA), 64'hDEAD_BEEF);
      r_finish(5, "bp");

      // Local write to reg[5] in the sampling cycle returns the old value.
      ar_issue(BASE + 32'h14);
      tick();
      loc_write(4'd5, 32'h1111_1111);
      chk("coll_rvalid", 64'(RVALID), 64'd1);
      chk("coll_rdata_old", 64'(RDATA), 64'h0);
      r_finish(0, "coll");
      do_read(BASE + 32'h14, 32'h1111_1111, 2'b00, "coll_new");

      // Reset while RVALID is held in RESP.
      ar_issue(BASE + 32'h0C);
      wait_rvalid(lat);
      chk("rr_pre_rvalid", 64'(RVALID), 64'd1);
      rst = 1'b1;
      #1;
      chk("rr_rvalid", 64'(RVALID), 64'd0);
      chk("rr_rdata", 64'(RDATA), 64'd0);
      chk("rr_arready", 64'(ARREADY), 64'd0);
      chk("rr_busy", 64'(busy), 64'd0);
      #10;
      rst = 1'b0;
      chk("rr_rel_arready_low", 64'(ARREADY), 64'd0);
      tick();
      chk("rr_rel_arready_high", 64'(ARREADY), 64'd1);
      do_read(BASE + 32'h0C, 32'h0, 2'b00, "rr_reg3_cleared");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axil_rd_slave_regbank.md
Name: axil_rd_slave_regbank

Overview:
AXI4-Lite read-only slave that sits directly downstream of the read master FSM and answers its AR/R handshakes from a local register bank. It replaces the dummy slave in the read path. Features:
- programmable response latency
- address range/alignment checking with SLVERR
- a local-side write port so the owning logic can update register contents

Parameters:
ADDR_WIDTH, 32, AR address width
DATA_WIDTH, 32, R data and register width
NUM_REGS, 16, number of DATA_WIDTH registers (power of two, >=2)
BASE_ADDR, 32'h0000_0000, byte address of register 0 (aligned to NUM_REGS*4)
RD_LATENCY, 2, cycles from AR handshake to RVALID assertion (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
ARADDR  in  ADDR_WIDTH  read address from master
ARVALID  in  1  read address valid
ARREADY  out  1  slave can accept address
RVALID  out  1  read data valid
RDATA  out  DATA_WIDTH  read data
RRESP  out  2  2'b00 OKAY, 2'b10 SLVERR
RREADY  in  1  master accepts read data
loc_wr_en  in  1  local register write strobe
loc_wr_idx  in  $clog2(NUM_REGS)  local write register index
loc_wr_data  in  DATA_WIDTH  local write data
busy  out  1  high while a transaction is in flight (not IDLE)

Behaviour:
- Clock is clk. Reset is asynchronous and active-high on rst. All state and outputs clear immediately on assertion.
- Reset values: ARREADY=0, RVALID=0, RDATA=0, RRESP=2'b00, busy=0, state=IDLE, latency counter=0, all registers=0.
- ARREADY is registered. It rises on the first clk edge after rst deasserts and is high only in IDLE.
- States:
  - IDLE: ARREADY=1. When ARVALID&&ARREADY:
    - capture ARADDR and decode
    - ARREADY->0
    - load counter with RD_LATENCY-1
    - go to WAIT
  - WAIT: decrement counter each cycle. At counter==0, register RDATA/RRESP, set RVALID=1 and go to RESP. With RD_LATENCY=1, RVALID is high on the edge after the AR handshake.
  - RESP: RVALID, RDATA and RRESP are held stable until RREADY. On RVALID&&RREADY: RVALID->0, RDATA->0, ARREADY->1, go to IDLE. The next AR handshake therefore needs at least one IDLE cycle; back-to-back reads have at least RD_LATENCY+2 cycles period.
- Only one outstanding transaction. ARVALID outside IDLE is ignored; the master must hold it.
- Decode:
  - off = ARADDR - BASE_ADDR
  - error if ARADDR < BASE_ADDR, or off >= NUM_REGS*4, or ARADDR[1:0] != 0
  - on error: RRESP=2'b10, RDATA=0
  - otherwise: RRESP=2'b00, RDATA=reg[off[$clog2(NUM_REGS)+1:2]]
- Data sampling: register contents are sampled in the WAIT cycle where counter==0, not at the AR handshake.
- Local write collision: a loc_wr_en to the same index in that sampling cycle returns the OLD value; the new value is visible to later reads.
- Local writes are accepted in every state and never stall the bus.
- busy = (state != IDLE).
- Reset mid-transaction (any state): abort immediately with outputs at reset values. No response is issued for the aborted read.

Decomposition:
- Shared package axil_pkg:
  - typedef resp_t (2 bits)
  - constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - enum rd_state_t {IDLE, WAIT, RESP}
- The master FSM imports the same package.
- One natural sub-module: axil_regbank. It holds the flop array with the local write port and a combinational read mux by index. The top holds the FSM, counter and decode.

Test Plan:
- Preload reg[3]=32'hDEAD_BEEF via local port; read ARADDR=BASE+0x0C, RD_LATENCY=2 -> RVALID 2 cycles after the AR handshake, RDATA=DEADBEEF, RRESP=00.
- Read ARADDR=BASE+0x40 (NUM_REGS=16) and ARADDR=BASE+0x06 -> each returns RRESP=10, RDATA=0; FSM returns to IDLE.
- Hold RREADY=0 for 5 cycles after RVALID -> RVALID/RDATA/RRESP stable for all 5 cycles; ARREADY=0 throughout; completes on the first RREADY=1 edge.
- loc_wr_en writes reg[5]=32'h1111_1111 in the sampling cycle of a read of reg[5], which previously held 32'h0 -> RDATA=0; an immediate second read -> 11111111.
- Assert rst while in RESP with RVALID=1 -> RVALID, ARREADY and RDATA drop to 0 asynchronously, registers clear; after release, ARREADY rises one edge later and a read of reg[3] returns 0.
- Full loop with the read master FSM, start pulse, reg[0]=32'hCAFE_F00D -> done asserted, READ_DATA=CAFEF00D.
